// File: rtl/instr_fetch_unit.sv
// Fetch stage ahead of the multicycle control FSM: owns the PC, fetches over imem req/ack,
// buffers the word and loads INSTRUCAO on LOAD_IR. Optional fetch timeout: FETCH_TIMEOUT_EN.
//
// state  | meaning
// F_REQ  | request outstanding for PC (imem_req=1)
// F_HOLD | buffer holds the word at PC (instr_ready=1)
// F_DROP | one-cycle request retraction after a PC change mid-fetch
module instr_fetch_unit #(
  parameter int              PC_W        = 64,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WRITE_PC,
  input  logic [PC_W-1:0] PC_IN,
  input  logic            LOAD_IR,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] PC,
  output logic [31:0]     INSTRUCAO,
  output logic [6:0]      op_code,
  output logic            instr_ready,
  output logic            fetch_err
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  if (TIMEOUT_CYC < 1) begin : g_timeout_range
    $error("instr_fetch_unit: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {F_REQ, F_HOLD, F_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] instr_buf;
  logic        ir_pending;
  logic        ack_take;
  logic        fill_nop;
  logic        timeout_hit;
  logic        ir_wanted;

  always_ff @(posedge CLK) begin
    if (RST) state <= F_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      F_REQ: begin
        if (WRITE_PC)                      state_nxt = F_DROP;
        else if (imem_ack || timeout_hit)  state_nxt = F_HOLD;
      end
      F_HOLD: if (WRITE_PC) state_nxt = F_REQ;
      F_DROP: state_nxt = WRITE_PC ? F_DROP : F_REQ;
      default: state_nxt = F_REQ;
    endcase
  end

  // A PC write in F_REQ discards any ack or timeout of that same cycle.
  always_comb begin
    imem_req    = (state == F_REQ) && !RST;
    instr_ready = (state == F_HOLD);
    ack_take    = (state == F_REQ) && imem_ack && !WRITE_PC;
    fill_nop    = timeout_hit && !WRITE_PC;
  end

  assign imem_addr = PC;
  assign op_code   = INSTRUCAO[6:0];
  assign ir_wanted = LOAD_IR || ir_pending;

  always_ff @(posedge CLK) begin
    if (RST) begin
      PC         <= RESET_PC;
      instr_buf  <= 32'h0;
      INSTRUCAO  <= 32'h0;
      ir_pending <= 1'b0;
    end else begin
      if (WRITE_PC) PC <= PC_IN;

      if (ack_take)      instr_buf <= imem_rdata;
      else if (fill_nop) instr_buf <= NOP_WORD;

      // IR always takes the buffered (old-PC) word when ready, even alongside a PC write.
      if (LOAD_IR && instr_ready) begin
        INSTRUCAO <= instr_buf;
      end else if (ir_wanted && ack_take) begin
        INSTRUCAO  <= imem_rdata;
        ir_pending <= 1'b0;
      end else if (ir_wanted && fill_nop) begin
        INSTRUCAO  <= NOP_WORD;
        ir_pending <= 1'b0;
      end else if (LOAD_IR) begin
        ir_pending <= 1'b1;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;

  assign timeout_hit = (state == F_REQ) && !imem_ack &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state != F_REQ || state_nxt != F_REQ || imem_ack) tmo_cnt <= '0;
      else                                                  tmo_cnt <= tmo_cnt + 1'b1;
      if (fill_nop) fetch_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

endmodule
